// File: rtl/sig_monitor.sv
// rtl/sig_monitor.sv - passive store snooper with signature capture and expected-table check
//
// Watches the shared mem_* bus without driving it. During a run, stores that land
// in the signature window update the captured words byte-lane by byte-lane. A store
// to the done address ends the run and starts a word-by-word compare against the
// expected table. A run that never signals completion is ended by a cycle timeout.
module sig_monitor #(
  parameter logic [31:0] SIG_BASE  = 32'h0000_0100,
  parameter int unsigned SIG_WORDS = 4,
  parameter logic [31:0] DONE_ADDR = 32'h0000_01FC,
  parameter int unsigned TIMEOUT   = 800,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned IDX_W    = (SIG_WORDS > 1) ? $clog2(SIG_WORDS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_valid,
  input  logic             mem_we,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  input  logic             mem_ready,
  input  logic             start,
  input  logic             exp_we,
  input  logic [IDX_W-1:0] exp_idx,
  input  logic [31:0]      exp_data,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [IDX_W-1:0] fail_idx,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_CHECK = 3'd2,
    S_PASS  = 3'd3,
    S_FAIL  = 3'd4
  } state_e;

  // Counter saturation value and the timeout threshold clamped to what the counter can hold.
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_CNT  =
    (64'(TIMEOUT) > 64'(CNT_MAX)) ? CNT_MAX : CNT_W'(TIMEOUT);

  state_e state_q, state_d;

  logic [31:0]      sig_q [SIG_WORDS];
  logic [31:0]      sig_d [SIG_WORDS];
  logic [31:0]      exp_q [SIG_WORDS];
  logic [31:0]      exp_d [SIG_WORDS];
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [IDX_W-1:0] chk_idx_q, chk_idx_d;
  logic [IDX_W-1:0] fail_idx_q, fail_idx_d;
  logic             timeout_q, timeout_d;

  logic             wr_beat;
  logic [29:0]      win_off;
  logic             win_hit;
  logic             done_hit;
  logic [CNT_W-1:0] cycles_inc;
  logic             timeout_hit;
  logic             chk_match;
  logic             chk_last;

  // Byte-offset bits of the snooped address carry no meaning for word-granular decode.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^mem_addr[1:0];

  // Bus decode: a write beat needs a handshake, write enable and at least one strobe.
  always_comb begin
    wr_beat     = mem_valid & mem_ready & mem_we & (|mem_wstrb);
    // Unsigned word offset from the window base; addresses below the base wrap to huge values.
    win_off     = mem_addr[31:2] - SIG_BASE[31:2];
    win_hit     = wr_beat && ({2'b00, win_off} < SIG_WORDS);
    done_hit    = wr_beat && (mem_addr[31:2] == DONE_ADDR[31:2]);
    cycles_inc  = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + 1'b1;
    timeout_hit = (cycles_inc == TO_CNT);
    chk_match   = (sig_q[chk_idx_q] == exp_q[chk_idx_q]);
    chk_last    = (32'(chk_idx_q) == SIG_WORDS - 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a done beat takes priority over a timeout landing on the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (done_hit)         state_d = S_CHECK;
        else if (timeout_hit) state_d = S_FAIL;
      end
      S_CHECK: begin
        if (!chk_match)    state_d = S_FAIL;
        else if (chk_last) state_d = S_PASS;
      end
      S_PASS:  state_d = S_PASS;
      S_FAIL:  state_d = S_FAIL;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    busy = (state_q == S_RUN) || (state_q == S_CHECK);
    done = (state_q == S_PASS) || (state_q == S_FAIL);
    pass = (state_q == S_PASS);
  end

  assign timeout  = timeout_q;
  assign fail_idx = fail_idx_q;
  assign cycles   = cycles_q;

  // Datapath next values: table loads in IDLE, capture and counting in RUN, compare walk in CHECK.
  always_comb begin
    sig_d      = sig_q;
    exp_d      = exp_q;
    cycles_d   = cycles_q;
    chk_idx_d  = chk_idx_q;
    fail_idx_d = fail_idx_q;
    timeout_d  = timeout_q;

    case (state_q)
      S_IDLE: begin
        for (int unsigned w = 0; w < SIG_WORDS; w++) begin
          if (exp_we && (32'(exp_idx) == w)) begin
            exp_d[w] = exp_data;
          end
        end
        if (start) begin
          for (int unsigned w = 0; w < SIG_WORDS; w++) begin
            sig_d[w] = 32'h0;
          end
          cycles_d   = '0;
          chk_idx_d  = '0;
          fail_idx_d = '0;
          timeout_d  = 1'b0;
        end
      end
      S_RUN: begin
        cycles_d  = cycles_inc;
        chk_idx_d = '0;
        for (int unsigned w = 0; w < SIG_WORDS; w++) begin
          if (win_hit && (win_off == 30'(w))) begin
            for (int b = 0; b < 4; b++) begin
              if (mem_wstrb[b]) sig_d[w][8*b +: 8] = mem_wdata[8*b +: 8];
            end
          end
        end
        if (!done_hit && timeout_hit) begin
          timeout_d = 1'b1;
        end
      end
      S_CHECK: begin
        if (!chk_match) begin
          fail_idx_d = chk_idx_q;
        end else if (!chk_last) begin
          chk_idx_d = chk_idx_q + 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath registers; reset clears captured words, expected table and all status.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned w = 0; w < SIG_WORDS; w++) begin
        sig_q[w] <= 32'h0;
        exp_q[w] <= 32'h0;
      end
      cycles_q   <= '0;
      chk_idx_q  <= '0;
      fail_idx_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      sig_q      <= sig_d;
      exp_q      <= exp_d;
      cycles_q   <= cycles_d;
      chk_idx_q  <= chk_idx_d;
      fail_idx_q <= fail_idx_d;
      timeout_q  <= timeout_d;
    end
  end

endmodule

// File: tb/tb_sig_monitor.sv
// tb/tb_sig_monitor.sv - directed bench for sig_monitor
module tb_sig_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic        start;
  logic        exp_we;
  logic [1:0]  exp_idx;
  logic [31:0] exp_data;
  logic        busy;
  logic        done;
  logic        pass;
  logic        timeout;
  logic [1:0]  fail_idx;
  logic [15:0] cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sig_monitor #(
    .SIG_BASE  (32'h0000_0100),
    .SIG_WORDS (4),
    .DONE_ADDR (32'h0000_01FC),
    .TIMEOUT   (20),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .start     (start),
    .exp_we    (exp_we),
    .exp_idx   (exp_idx),
    .exp_data  (exp_data),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .timeout   (timeout),
    .fail_idx  (fail_idx),
    .cycles    (cycles)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_idle();
    mem_valid = 1'b0;
    mem_we    = 1'b0;
    mem_ready = 1'b0;
    mem_addr  = 32'h0;
    mem_wdata = 32'h0;
    mem_wstrb = 4'h0;
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    mem_valid = 1'b1;
    mem_we    = 1'b1;
    mem_ready = 1'b1;
    mem_addr  = a;
    mem_wdata = d;
    mem_wstrb = s;
    step();
    bus_idle();
  endtask

  task automatic load_exp(input logic [1:0] i, input logic [31:0] d);
    exp_we   = 1'b1;
    exp_idx  = i;
    exp_data = d;
    step();
    exp_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus_idle();
    start    = 1'b0;
    exp_we   = 1'b0;
    exp_idx  = 2'd0;
    exp_data = 32'h0;
    rst      = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_pass",     32'(pass),     32'd0);
    chk("rst_timeout",  32'(timeout),  32'd0);
    chk("rst_fail_idx", 32'(fail_idx), 32'd0);
    chk("rst_cycles",   32'(cycles),   32'd0);

    // Done-address store while idle must not start anything.
    beat(32'h1FC, 32'h1, 4'hF);
    chk("idle_beat_busy", 32'(busy), 32'd0);

    // T1: single matching word, completion store, 4-cycle check.
    load_exp(2'd0, 32'hA1);
    pulse_start();
    chk("t1_busy_run",  32'(busy),   32'd1);
    chk("t1_cycles0",   32'(cycles), 32'd0);
    load_exp(2'd1, 32'hFF);
    beat(32'h100, 32'hA1, 4'hF);
    beat(32'h1FC, 32'h0, 4'h1);
    chk("t1_in_check",  32'(busy),   32'd1);
    chk("t1_cyc_frz",   32'(cycles), 32'd3);
    step(); step(); step();
    chk("t1_not_done3", 32'(done),   32'd0);
    step();
    chk("t1_done",      32'(done),     32'd1);
    chk("t1_pass",      32'(pass),     32'd1);
    chk("t1_timeout",   32'(timeout),  32'd0);
    chk("t1_fail_idx",  32'(fail_idx), 32'd0);
    chk("t1_cycles",    32'(cycles),   32'd3);
    chk("t1_busy_end",  32'(busy),     32'd0);

    // T2: mismatch on word 2.
    do_reset();
    chk("t2_rst_done",  32'(done), 32'd0);
    load_exp(2'd2, 32'h55);
    pulse_start();
    beat(32'h108, 32'h54, 4'hF);
    beat(32'h1FC, 32'h0, 4'hF);
    step(); step();
    chk("t2_not_done",  32'(done),     32'd0);
    step();
    chk("t2_done",      32'(done),     32'd1);
    chk("t2_pass",      32'(pass),     32'd0);
    chk("t2_fail_idx",  32'(fail_idx), 32'd2);
    chk("t2_timeout",   32'(timeout),  32'd0);

    // T4: partial-strobe merge plus ignored read, unhandshaken and zero-strobe writes.
    do_reset();
    load_exp(2'd1, 32'h1122AA44);
    pulse_start();
    beat(32'h104, 32'h11223344, 4'hF);
    beat(32'h104, 32'hAAAAAAAA, 4'b0010);
    mem_valid = 1'b1; mem_ready = 1'b1; mem_we = 1'b0;
    mem_addr = 32'h104; mem_wdata = 32'h0; mem_wstrb = 4'hF;
    step();
    mem_we = 1'b1; mem_ready = 1'b0;
    step();
    mem_ready = 1'b1; mem_wstrb = 4'h0;
    step();
    bus_idle();
    beat(32'h1FC, 32'h0, 4'hF);
    step(); step(); step(); step();
    chk("t4_pass",      32'(pass),   32'd1);
    chk("t4_cycles",    32'(cycles), 32'd6);

    // T3: no completion store, timeout after 20 run cycles.
    do_reset();
    pulse_start();
    repeat (19) step();
    chk("t3_cycles19",  32'(cycles), 32'd19);
    chk("t3_busy19",    32'(busy),   32'd1);
    step();
    chk("t3_done",      32'(done),     32'd1);
    chk("t3_timeout",   32'(timeout),  32'd1);
    chk("t3_pass",      32'(pass),     32'd0);
    chk("t3_cycles",    32'(cycles),   32'd20);
    chk("t3_fail_idx",  32'(fail_idx), 32'd0);
    beat(32'h100, 32'h12345678, 4'hF);
    beat(32'h1FC, 32'h0, 4'hF);
    pulse_start();
    chk("t3_hold_done", 32'(done),    32'd1);
    chk("t3_hold_to",   32'(timeout), 32'd1);
    chk("t3_hold_cyc",  32'(cycles),  32'd20);
    chk("t3_hold_busy", 32'(busy),    32'd0);

    // T5: handshake-less done address is not an end; done beat on the timeout cycle wins.
    do_reset();
    pulse_start();
    repeat (4) step();
    mem_valid = 1'b1; mem_we = 1'b1; mem_ready = 1'b0;
    mem_addr = 32'h1FC; mem_wstrb = 4'hF;
    step();
    bus_idle();
    step();
    chk("t5_no_end_cyc", 32'(cycles), 32'd6);
    chk("t5_no_end_bsy", 32'(busy),   32'd1);
    repeat (13) step();
    beat(32'h1FC, 32'h0, 4'hF);
    chk("t5_check_busy", 32'(busy),    32'd1);
    chk("t5_check_done", 32'(done),    32'd0);
    chk("t5_timeout0",   32'(timeout), 32'd0);
    chk("t5_cycles",     32'(cycles),  32'd20);
    step(); step(); step(); step();
    chk("t5_pass",       32'(pass),    32'd1);
    chk("t5_timeout_e",  32'(timeout), 32'd0);

    // T6: reset in the middle of CHECK clears everything including the expected table.
    do_reset();
    load_exp(2'd0, 32'h77);
    pulse_start();
    beat(32'h1FC, 32'h0, 4'hF);
    chk("t6_in_check",  32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy",      32'(busy),     32'd0);
    chk("t6_done",      32'(done),     32'd0);
    chk("t6_pass",      32'(pass),     32'd0);
    chk("t6_timeout",   32'(timeout),  32'd0);
    chk("t6_fail_idx",  32'(fail_idx), 32'd0);
    chk("t6_cycles",    32'(cycles),   32'd0);
    pulse_start();
    beat(32'h1FC, 32'h0, 4'hF);
    step(); step(); step(); step();
    chk("t6_exp_clear", 32'(pass), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
